// File: rtl/johnson_pkg.sv
// Shared Johnson-code definitions: tracker state encoding plus legality and index helpers.
// Used by the receive-side decoder and by counter-side test code.
package johnson_pkg;

    typedef enum logic {
        ST_UNLOCK = 1'b0,
        ST_LOCKED = 1'b1
    } jc_state_e;

    localparam int JC_MAX_N = 32;

    // A Johnson word has at most one transition between adjacent bits.
    function automatic logic jc_legal(input logic [JC_MAX_N-1:0] code, input int n);
        int trans;
        trans = 0;
        for (int i = 0; i < JC_MAX_N - 1; i++) begin
            if ((i < n - 1) && (code[i] != code[i+1])) trans++;
        end
        return (trans <= 1);
    endfunction

    function automatic int jc_to_idx(input logic [JC_MAX_N-1:0] code, input int n);
        int pop;
        pop = 0;
        for (int i = 0; i < JC_MAX_N; i++) begin
            if ((i < n) && code[i]) pop++;
        end
        return code[n-1] ? (2 * n - pop) : pop;
    endfunction

endpackage

// File: rtl/johnson_decoder_code_to_index.sv
// Combinational Johnson-code legality check and binary index decode.
module johnson_code_to_index
    import johnson_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(2 * N)
) (
    input  logic [N-1:0]     code_i,
    output logic             legal_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [JC_MAX_N-1:0] code_ext;

    always_comb begin
        code_ext = JC_MAX_N'(code_i);
        legal_o  = jc_legal(code_ext, N);
        idx_o    = IDX_W'(jc_to_idx(code_ext, N));
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes index/one-hot, tracks step continuity, direction and lock.
// Optional saturating error counter when JOHNSON_DEC_ERRCNT_EN is defined.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int IDX_W    = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [N-1:0]     code,
    output logic [IDX_W-1:0] idx,
    output logic [2*N-1:0]   onehot,
    output logic             idx_valid,
    output logic             locked,
    output logic             dir,
    output logic             step_err,
    output logic             illegal
`ifdef JOHNSON_DEC_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam logic [SW-1:0]  LOCK_STREAK = SW'(LOCK_CNT);
    localparam logic [IDX_W:0] TWO_N       = (IDX_W + 1)'(2 * N);
    localparam logic [IDX_W:0] D_HOLD      = '0;
    localparam logic [IDX_W:0] D_FWD       = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0] D_REV       = (IDX_W + 1)'(2 * N - 1);

    jc_state_e        state_q, state_d;
    logic             ref_valid_q, ref_valid_d;
    logic [IDX_W-1:0] ref_idx_q, ref_idx_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             step_err_q, step_err_d;
    logic             illegal_q, illegal_d;

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W:0]   diff, delta;
    logic             is_fwd, is_rev;

    johnson_code_to_index #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_decode (
        .code_i  (code),
        .legal_o (dec_legal),
        .idx_o   (dec_idx)
    );

    // Extra bit keeps the sign of new-ref so the modulo fold works for any N.
    always_comb begin
        diff   = {1'b0, dec_idx} - {1'b0, ref_idx_q};
        delta  = diff[IDX_W] ? (diff + TWO_N) : diff;
        is_fwd = (delta == D_FWD);
        is_rev = (delta == D_REV);
    end

    always_comb begin
        state_d     = state_q;
        ref_valid_d = ref_valid_q;
        ref_idx_d   = ref_idx_q;
        streak_d    = streak_q;
        dir_d       = dir_q;
        idx_d       = idx_q;
        idx_valid_d = idx_valid_q;
        step_err_d  = 1'b0;
        illegal_d   = 1'b0;

        if (code_valid) begin
            if (!dec_legal) begin
                illegal_d   = 1'b1;
                idx_valid_d = 1'b0;
                state_d     = ST_UNLOCK;
                ref_valid_d = 1'b0;
                streak_d    = '0;
            end else begin
                idx_d       = dec_idx;
                idx_valid_d = 1'b1;
                ref_idx_d   = dec_idx;
                ref_valid_d = 1'b1;
                if (!ref_valid_q) begin
                    streak_d = '0;
                    state_d  = ST_UNLOCK;
                end else begin
                    case (state_q)
                        ST_UNLOCK: begin
                            if (is_fwd || is_rev) begin
                                if (is_fwd == dir_q) begin
                                    streak_d = streak_q + 1'b1;
                                end else begin
                                    dir_d    = is_fwd;
                                    streak_d = SW'(1);
                                end
                                if (streak_d >= LOCK_STREAK) state_d = ST_LOCKED;
                            end else if (delta != D_HOLD) begin
                                streak_d = '0;
                            end
                        end
                        ST_LOCKED: begin
                            if (is_fwd || is_rev) begin
                                dir_d = is_fwd;
                            end else if (delta != D_HOLD) begin
                                step_err_d = 1'b1;
                                state_d    = ST_UNLOCK;
                                streak_d   = '0;
                            end
                        end
                        default: state_d = ST_UNLOCK;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_UNLOCK;
            ref_valid_q <= 1'b0;
            ref_idx_q   <= '0;
            streak_q    <= '0;
            dir_q       <= 1'b1;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_valid_q <= ref_valid_d;
            ref_idx_q   <= ref_idx_d;
            streak_q    <= streak_d;
            dir_q       <= dir_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            step_err_q  <= step_err_d;
            illegal_q   <= illegal_d;
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((step_err_d || illegal_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

    always_comb begin
        onehot = '0;
        if (idx_valid_q) onehot[idx_q] = 1'b1;
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = (state_q == ST_LOCKED);
    assign dir       = dir_q;
    assign step_err  = step_err_q;
    assign illegal   = illegal_q;

endmodule
